// File: rtl/dual_grant_scheduler_pkg.sv
// Shared definitions for the dual-grant request scheduler.
// Provides the request/index/counter widths, the scheduler state encoding
// and the index-to-bitmask helper that matches the encoder's priority order.
package dual_grant_scheduler_pkg;

  localparam int N_REQ = 12;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE1 = 2'd1,
    ST_ISSUE2 = 2'd2
  } state_e;

  // Index k names request bit N_REQ-1-k (index 0 is the MSB, highest priority).
  function automatic logic [N_REQ-1:0] idx_to_mask(input logic [IDX_W-1:0] k);
    logic [N_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(k) == N_REQ - 1 - i) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/dual_grant_scheduler_if.sv
// Grant handshake bundle between the scheduler and its consumer.
// Ports: gnt_valid/gnt_idx/gnt_second driven by the scheduler (master),
//        gnt_ready driven by the consumer (slave).
interface dual_grant_scheduler_if;
  import dual_grant_scheduler_pkg::*;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_second;
  logic             gnt_ready;

  modport master (
    output gnt_valid,
    output gnt_idx,
    output gnt_second,
    input  gnt_ready
  );

  modport slave (
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_second,
    output gnt_ready
  );

endinterface

// File: rtl/dual_grant_scheduler_dpe.sv
// 12-input dual priority encoder: first and second set bits, MSB first.
// Ports: a_i request vector; y1_o index of highest-priority set bit,
//        y2_o index of next set bit (both 0 when no such bit exists).
module dual_priority_encode
  import dual_grant_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] a_i,
  output logic [IDX_W-1:0] y1_o,
  output logic [IDX_W-1:0] y2_o
);

  logic found1;
  logic found2;

  always_comb begin
    y1_o   = '0;
    y2_o   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (a_i[N_REQ-1-k]) begin
        if (!found1) begin
          y1_o   = IDX_W'(k);
          found1 = 1'b1;
        end else if (!found2) begin
          y2_o   = IDX_W'(k);
          found2 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_grant_scheduler.sv
// Sticky-request scheduler issuing up to two fixed-priority grants per round.
// Ports: clk/rst (sync, active-high); req_in request pulses; enc_a/enc_y1/enc_y2
//        encoder link; gnt grant handshake (master); busy; gnt_count accepted grants.
module dual_grant_scheduler
  import dual_grant_scheduler_pkg::*;
#(
  // 1: take Y_1/Y_2 from the enc_y* ports (standalone build with an external
  // encoder). 0: use the embedded encoder; enc_y* are then ignored.
  parameter bit EXT_ENC = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_in,
  output logic [N_REQ-1:0]     enc_a,
  input  logic [IDX_W-1:0]     enc_y1,
  input  logic [IDX_W-1:0]     enc_y2,
  dual_grant_scheduler_if.master gnt,
  output logic                 busy,
  output logic [CNT_W-1:0]     gnt_count
);

  logic [N_REQ-1:0] pend_q, pend_d, clr_mask;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] h1_q, h1_d, h2_q, h2_d;
  logic             hv2_q, hv2_d;

  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_second_q, gnt_second_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] int_y1, int_y2, y1, y2;
  logic             v1, v2, hs;

  assign enc_a = pend_q;

  dual_priority_encode u_enc (
    .a_i  (pend_q),
    .y1_o (int_y1),
    .y2_o (int_y2)
  );

  assign y1 = EXT_ENC ? enc_y1 : int_y1;
  assign y2 = EXT_ENC ? enc_y2 : int_y2;

  // The encoder carries no valid flag: derive it from the population of pend.
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign v1 = |pend_q;
  assign v2 = |(pend_q & (pend_q - {{(N_REQ-1){1'b0}}, 1'b1}));

  assign hs = gnt_valid_q & gnt.gnt_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      h1_q         <= '0;
      h2_q         <= '0;
      hv2_q        <= 1'b0;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_second_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      hv2_q        <= hv2_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_second_q <= gnt_second_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic, including the pending-vector update
  always_comb begin
    state_d  = state_q;
    h1_d     = h1_q;
    h2_d     = h2_q;
    hv2_d    = hv2_q;
    clr_mask = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (v1) begin
          h1_d     = y1;
          h2_d     = v2 ? y2 : '0;
          hv2_d    = v2;
          clr_mask = idx_to_mask(y1) | (v2 ? idx_to_mask(y2) : '0);
          state_d  = ST_ISSUE1;
        end
      end
      ST_ISSUE1: begin
        if (hs) state_d = hv2_q ? ST_ISSUE2 : ST_IDLE;
      end
      ST_ISSUE2: begin
        if (hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // New requests are OR-ed in after the clear, so a same-cycle set survives.
    pend_d = (pend_q & ~clr_mask) | req_in;
  end

  // Output logic: next values of the registered grant outputs
  always_comb begin
    gnt_valid_d  = (state_d != ST_IDLE);
    gnt_second_d = (state_d == ST_ISSUE2);
    gnt_idx_d    = '0;
    if (state_d == ST_ISSUE1) gnt_idx_d = h1_d;
    else if (state_d == ST_ISSUE2) gnt_idx_d = h2_q;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, hs};
  end

  assign gnt.gnt_valid  = gnt_valid_q;
  assign gnt.gnt_idx    = gnt_idx_q;
  assign gnt.gnt_second = gnt_second_q;
  assign gnt_count      = cnt_q;
  assign busy           = (state_q != ST_IDLE) | (|pend_q);

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Self-checking bench for dual_grant_scheduler: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_dual_grant_scheduler;
  import dual_grant_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [11:0]      req;
  logic [11:0]      enc_a;
  logic             busy;
  logic [7:0]       gnt_count;

  dual_grant_scheduler_if gif ();

  dual_grant_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req),
    .enc_a     (enc_a),
    .enc_y1    (4'd0),
    .enc_y2    (4'd0),
    .gnt       (gif),
    .busy      (busy),
    .gnt_count (gnt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A round is modelled as a queue of outstanding grants; the head is what
  // must be presented. A new round may only be taken when the queue was
  // empty at the clock edge.
  typedef struct {
    int idx;
    bit second;
  } g_t;

  g_t   mq[$];
  int   m_pend;
  int   m_cnt;
  int   m_total;
  bit   m_ok = 1'b0;
  bit   m_empty;
  int   m_clr;
  int   m_n;
  g_t   m_g;

  always @(posedge clk) begin
    if (rst) begin
      m_pend  = 0;
      mq.delete();
      m_cnt   = 0;
      m_total = 0;
    end else begin
      m_empty = (mq.size() == 0);
      if (!m_empty && gif.gnt_ready) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % 256;
        m_total++;
      end
      m_clr = 0;
      if (m_empty && m_pend != 0) begin
        m_n = 0;
        for (int k = 0; k < 12; k++) begin
          if (m_pend[11-k] && m_n < 2) begin
            m_g.idx    = k;
            m_g.second = (m_n == 1);
            mq.push_back(m_g);
            m_clr = m_clr | (1 << (11 - k));
            m_n++;
          end
        end
      end
      m_pend = (m_pend & ~m_clr) | int'(req);
    end
    m_ok = 1'b1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("gnt_valid",  int'(gif.gnt_valid),  (mq.size() > 0) ? 1 : 0);
      chk("gnt_idx",    int'(gif.gnt_idx),    (mq.size() > 0) ? mq[0].idx : 0);
      chk("gnt_second", int'(gif.gnt_second), (mq.size() > 0) ? int'(mq[0].second) : 0);
      chk("enc_a",      int'(enc_a),          m_pend);
      chk("busy",       int'(busy),           (mq.size() > 0 || m_pend != 0) ? 1 : 0);
      chk("gnt_count",  int'(gnt_count),      m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req = '0;
    gif.gnt_ready = 1'b0;
    cyc(2);
    chk("rst_valid", int'(gif.gnt_valid), 0);
    chk("rst_enc_a", int'(enc_a), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_count", int'(gnt_count), 0);
    rst = 1'b0;

    // Single request, index 0
    req = 12'h800;
    cyc(1);
    req = '0;
    chk("t1_pend", int'(enc_a), 12'h800);
    chk("t1_novalid", int'(gif.gnt_valid), 0);
    cyc(1);
    chk("t1_valid", int'(gif.gnt_valid), 1);
    chk("t1_idx", int'(gif.gnt_idx), 0);
    chk("t1_second", int'(gif.gnt_second), 0);
    gif.gnt_ready = 1'b1;
    cyc(1);
    chk("t1_idle", int'(gif.gnt_valid), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_count", int'(gnt_count), 1);

    // Three requests: pair then single
    req = 12'h700;
    cyc(1);
    req = '0;
    cyc(1);
    chk("t2_idx_a", int'(gif.gnt_idx), 1);
    chk("t2_sec_a", int'(gif.gnt_second), 0);
    chk("t2_pend", int'(enc_a), 12'h100);
    cyc(1);
    chk("t2_idx_b", int'(gif.gnt_idx), 2);
    chk("t2_sec_b", int'(gif.gnt_second), 1);
    cyc(2);
    chk("t2_idx_c", int'(gif.gnt_idx), 3);
    chk("t2_sec_c", int'(gif.gnt_second), 0);
    cyc(1);
    chk("t2_count", int'(gnt_count), 4);

    // Backpressure: grant must hold stable
    gif.gnt_ready = 1'b0;
    req = 12'h900;
    cyc(1);
    req = '0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", int'(gif.gnt_valid), 1);
      chk("t3_hold_idx", int'(gif.gnt_idx), 0);
      cyc(1);
    end
    gif.gnt_ready = 1'b1;
    cyc(1);
    chk("t3_idx2", int'(gif.gnt_idx), 3);
    chk("t3_sec2", int'(gif.gnt_second), 1);
    cyc(1);
    chk("t3_count", int'(gnt_count), 6);

    // Re-request of an in-flight index
    gif.gnt_ready = 1'b0;
    req = 12'hC00;
    cyc(1);
    req = '0;
    cyc(1);
    req = 12'h800;
    cyc(1);
    req = '0;
    chk("t4_repend", int'(enc_a), 12'h800);
    chk("t4_hold", int'(gif.gnt_idx), 0);
    gif.gnt_ready = 1'b1;
    cyc(3);
    chk("t4_again_v", int'(gif.gnt_valid), 1);
    chk("t4_again_idx", int'(gif.gnt_idx), 0);
    chk("t4_again_sec", int'(gif.gnt_second), 0);
    cyc(1);
    chk("t4_count", int'(gnt_count), 9);

    // Set wins over clear on the capture cycle
    req = 12'hC00;
    cyc(1);
    req = 12'h800;
    cyc(1);
    req = '0;
    chk("t5_pend", int'(enc_a), 12'h800);
    chk("t5_idx_a", int'(gif.gnt_idx), 0);
    cyc(1);
    chk("t5_idx_b", int'(gif.gnt_idx), 1);
    chk("t5_sec_b", int'(gif.gnt_second), 1);
    cyc(2);
    chk("t5_idx_c", int'(gif.gnt_idx), 0);
    chk("t5_sec_c", int'(gif.gnt_second), 0);
    cyc(1);
    chk("t5_count", int'(gnt_count), 12);

    // Reset in the middle of the second grant
    req = 12'hC00;
    cyc(1);
    req = 12'h00F;
    cyc(1);
    req = '0;
    cyc(1);
    chk("t6_sec", int'(gif.gnt_second), 1);
    chk("t6_pend", int'(enc_a), 12'h00F);
    rst = 1'b1;
    cyc(1);
    chk("t6_valid", int'(gif.gnt_valid), 0);
    chk("t6_enc_a", int'(enc_a), 0);
    chk("t6_count", int'(gnt_count), 0);
    chk("t6_busy", int'(busy), 0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h000;
      gif.gnt_ready = ($urandom_range(0, 9) < 7);
      cyc(1);
    end

    // Counter wrap after 256 accepted grants
    rst = 1'b1;
    req = '0;
    cyc(1);
    rst = 1'b0;
    gif.gnt_ready = 1'b1;
    req = 12'hFFF;
    for (int w = 0; w < 2000; w++) begin
      cyc(1);
      if (m_total >= 256) break;
    end
    if (m_total == 256) chk("wrap_count", int'(gnt_count), 0);
    else chk("wrap_reached", m_total, 256);
    req = '0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
